fsic_cfg_hub: RTL and testbench

//  AXI4-Lite configuration hub for the FSIC FPGA platform at base 0x6000_0000.

---
 rtl/fsic_cfg_hub.sv | 231 +++++++++++++++++++++++
 tb/tb_fsic_cfg_hub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsic_cfg_hub.sv
// AXI4-Lite configuration hub for the FSIC FPGA platform: decodes 4 KB windows into
// SoC-side and FPGA-local config regions, models Caravel boot status on mprj_o.
module fsic_cfg_hub #(
  parameter logic [31:0] BASE_ADDR   = 32'h6000_0000,
  parameter int unsigned BOOT_CYCLES = 1000,
  parameter int unsigned SOC_LATENCY = 16
) (
  input  logic        sys_clock,
  input  logic        sys_reset,
  input  logic        resetb_0,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [1:0]  mprj_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_W_ACC, ST_R_ACC, ST_WAIT, ST_B_RESP, ST_R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // ---------------- Caravel boot model ----------------
  logic [1:0]  rstb_sync;
  logic [31:0] boot_cnt;
  logic        fw_ready;

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      rstb_sync <= '0;
      boot_cnt  <= '0;
    end else begin
      rstb_sync <= {rstb_sync[0], resetb_0};
      if (!rstb_sync[1])
        boot_cnt <= '0;
      else if (boot_cnt < 32'(BOOT_CYCLES))
        boot_cnt <= boot_cnt + 32'd1;
    end
  end

  assign fw_ready = rstb_sync[1] && (boot_cnt >= 32'(BOOT_CYCLES));
  assign mprj_o   = {2{fw_ready}};

  // ---------------- Register file ----------------
  logic [4:0]  soc_cc;
  logic [31:0] soc_la;
  logic [31:0] soc_up [16];
  logic [31:0] pl_aa;
  logic [31:0] mbox [8];
  logic [1:0]  pl_is;

  state_t state;

  // Address decode is shared between the write and read paths; only one is ever in flight.
  logic [31:0] dec_addr;
  logic [3:0]  region;
  logic [11:0] off;
  logic        dec_err, soc_region, gate_block, off_zero, up_hit, mbox_hit;
  logic        delayed;
  logic [1:0]  resp_code;
  logic [31:0] rd_val, wr_new;
  logic        wr_ok;
  logic        unused_addr_bits;

  assign dec_addr         = (state == ST_W_ACC) ? s_axi_awaddr : s_axi_araddr;
  assign region           = dec_addr[15:12];
  assign off              = dec_addr[11:0];
  assign unused_addr_bits = ^dec_addr[1:0];
  assign dec_err    = (dec_addr[31:16] != BASE_ADDR[31:16]) || (region > 4'h8);
  assign soc_region = (region == 4'h0) || (region == 4'h1) || (region == 4'h3) ||
                      (region == 4'h4) || (region == 4'h5);
  assign gate_block = !dec_err && soc_region && !(fw_ready && pl_is == 2'b11);
  assign off_zero   = (off[11:2] == 10'd0);
  assign up_hit     = (off[11:6] == 6'd0);
  assign mbox_hit   = (off[11:8] == 4'h1) && (off[7:5] == 3'd0);
  assign delayed    = !dec_err && !gate_block && soc_region && (SOC_LATENCY != 0);
  assign resp_code  = dec_err ? RESP_DECERR : (gate_block ? RESP_SLVERR : RESP_OKAY);
  assign wr_ok      = (state == ST_W_ACC) && !dec_err && !gate_block;

  always_comb begin
    rd_val = '0;
    unique case (region)
      4'h0: if (up_hit) rd_val = soc_up[off[5:2]];
      4'h1: if (off_zero) rd_val = soc_la;
      4'h2: begin
        if (off_zero)      rd_val = pl_aa;
        else if (mbox_hit) rd_val = mbox[off[4:2]];
      end
      4'h3: if (off_zero) rd_val = 32'h1;
      4'h4: if (off_zero) rd_val = 32'hF;
      4'h5: if (off_zero) rd_val = {27'd0, soc_cc};
      4'h6: if (off_zero) rd_val = 32'h6;
      4'h7: if (off_zero) rd_val = {30'd0, pl_is};
      4'h8: if (off_zero) rd_val = 32'h4;
      default: rd_val = '0;
    endcase
  end

  // Current register value merged with the strobed write bytes.
  always_comb begin
    wr_new = rd_val;
    for (int unsigned i = 0; i < 4; i++)
      if (s_axi_wstrb[i]) wr_new[8*i +: 8] = s_axi_wdata[8*i +: 8];
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      soc_cc <= 5'h1F;
      soc_la <= '0;
      pl_aa  <= '0;
      pl_is  <= '0;
      for (int unsigned i = 0; i < 16; i++) soc_up[i] <= '0;
      for (int unsigned i = 0; i < 8; i++)  mbox[i]   <= '0;
    end else if (wr_ok) begin
      unique case (region)
        4'h0: if (up_hit) soc_up[off[5:2]] <= wr_new;
        4'h1: if (off_zero) soc_la <= wr_new;
        4'h2: begin
          if (off_zero)      pl_aa <= wr_new;
          else if (mbox_hit) mbox[off[4:2]] <= wr_new;
        end
        4'h5: if (off_zero) soc_cc <= wr_new[4:0];
        4'h7: if (off_zero) pl_is <= wr_new[1:0];
        default: ;
      endcase
    end
  end

  // ---------------- Transaction FSM ----------------
  logic [31:0] lat_cnt;
  logic        pend_write;

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      state         <= ST_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      lat_cnt       <= '0;
      pend_write    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // Ready is raised one cycle ahead; the handshake completes in the *_ACC state.
          if (s_axi_awvalid && s_axi_wvalid) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            state         <= ST_W_ACC;
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b1;
            state         <= ST_R_ACC;
          end
        end
        ST_W_ACC: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bresp   <= resp_code;
          pend_write    <= 1'b1;
          if (delayed) begin
            lat_cnt <= 32'(SOC_LATENCY);
            state   <= ST_WAIT;
          end else begin
            s_axi_bvalid <= 1'b1;
            state        <= ST_B_RESP;
          end
        end
        ST_R_ACC: begin
          s_axi_arready <= 1'b0;
          s_axi_rresp   <= resp_code;
          s_axi_rdata   <= (resp_code == RESP_OKAY) ? rd_val : '0;
          pend_write    <= 1'b0;
          if (delayed) begin
            lat_cnt <= 32'(SOC_LATENCY);
            state   <= ST_WAIT;
          end else begin
            s_axi_rvalid <= 1'b1;
            state        <= ST_R_RESP;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 32'd1) begin
            if (pend_write) begin
              s_axi_bvalid <= 1'b1;
              state        <= ST_B_RESP;
            end else begin
              s_axi_rvalid <= 1'b1;
              state        <= ST_R_RESP;
            end
          end else begin
            lat_cnt <= lat_cnt - 32'd1;
          end
        end
        ST_B_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsic_cfg_hub.sv
// Directed bench for fsic_cfg_hub: boot timing, SoC gating, register map, decode errors,
// write/read arbitration and mid-transaction reset.
module tb_fsic_cfg_hub;
  localparam int unsigned BC  = 20;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        sys_reset, resetb_0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp, mprj;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fsic_cfg_hub #(.BASE_ADDR(32'h6000_0000), .BOOT_CYCLES(BC), .SOC_LATENCY(LAT)) dut (
    .sys_clock(clk), .sys_reset(sys_reset), .resetb_0(resetb_0),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mprj_o(mprj)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no handshake expected handshake within 100 cycles", tag);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 100) begin @(negedge clk); n++; end
    if (!(awready && wready)) begin
      timeout_fail("aw_handshake"); awvalid = 1'b0; wvalid = 1'b0; return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (!bvalid) begin timeout_fail("bvalid"); return; end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    data = 'x; resp = 2'bxx; lat = -1;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) begin timeout_fail("ar_handshake"); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) begin timeout_fail("rvalid"); return; end
    lat = n; data = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          lat, n;

    sys_reset = 1'b0; resetb_0 = 1'b1;
    awaddr = '0; wdata = '0; wstrb = 4'hF; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_mprj",    {30'd0, mprj},    32'd0);

    // Boot: firmware ready exactly BOOT_CYCLES+2 clocks after release
    @(negedge clk); sys_reset = 1'b1;
    repeat (BC + 1) @(posedge clk);
    #1 check("boot_early", {30'd0, mprj}, 32'd0);
    @(posedge clk);
    #1 check("boot_ready", {30'd0, mprj}, 32'd3);

    // SoC gate closed until PL_IS == 3
    axi_read(32'h6000_5000, d, r, lat);
    check("gate_cc_resp", {30'd0, r}, 32'd2);
    check("gate_cc_data", d, 32'd0);
    axi_write(32'h6000_7000, 32'h1, 4'hF, r);
    check("pl_is1_bresp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_5000, d, r, lat);
    check("gate_half_resp", {30'd0, r}, 32'd2);
    axi_write(32'h6000_7000, 32'h3, 4'hF, r);
    check("pl_is3_bresp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_7000, d, r, lat);
    check("pl_is_data", d, 32'd3);
    check("pl_is_resp", {30'd0, r}, 32'd0);
    check("pl_is_lat", lat, 32'd0);

    // Reset values with the gate open
    axi_read(32'h6000_5000, d, r, lat);
    check("soc_cc_rst", d, 32'h1F); check("soc_cc_resp", {30'd0, r}, 32'd0);
    check("soc_cc_lat", lat, LAT);
    axi_read(32'h6000_4000, d, r, lat);
    check("soc_as_rst", d, 32'hF); check("soc_as_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_3000, d, r, lat);
    check("soc_is_rst", d, 32'h1); check("soc_is_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_1000, d, r, lat);
    check("soc_la_rst", d, 32'h0); check("soc_la_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_6000, d, r, lat);
    check("pl_as_rst", d, 32'h6); check("pl_as_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_8000, d, r, lat);
    check("pl_dma_rst", d, 32'h4); check("pl_dma_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_2000, d, r, lat);
    check("pl_aa_rst", d, 32'h0); check("pl_aa_resp", {30'd0, r}, 32'd0);

    // SOC_CC sweep
    for (int i = 0; i < 32; i++) begin
      axi_write(32'h6000_5000, 32'(i), 4'hF, r);
      check("cc_sweep_bresp", {30'd0, r}, 32'd0);
      axi_read(32'h6000_5000, d, r, lat);
      check("cc_sweep_data", d, 32'(i));
    end
    axi_write(32'h6000_5000, 32'hFFFF_FFE0, 4'hF, r);
    axi_read(32'h6000_5000, d, r, lat);
    check("cc_upper_ignored", d, 32'h0);

    // Read-only region and decode errors
    axi_write(32'h6000_4000, 32'hFFFF_FFFF, 4'hF, r);
    check("soc_as_wr_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_4000, d, r, lat);
    check("soc_as_ro", d, 32'hF);
    axi_read(32'h6000_9000, d, r, lat);
    check("decerr_reg9_resp", {30'd0, r}, 32'd3); check("decerr_reg9_data", d, 32'd0);
    axi_read(32'h7000_7000, d, r, lat);
    check("decerr_base_resp", {30'd0, r}, 32'd3);
    axi_write(32'h6000_9000, 32'h1234, 4'hF, r);
    check("decerr_wr_resp", {30'd0, r}, 32'd3);
    axi_read(32'h6000_7004, d, r, lat);
    check("hole_data", d, 32'd0); check("hole_resp", {30'd0, r}, 32'd0);

    // Byte strobes, mailbox, SOC_UP scratch
    axi_write(32'h6000_2000, 32'h1122_3344, 4'hF, r);
    axi_write(32'h6000_2000, 32'hAABB_CCDD, 4'b0101, r);
    axi_read(32'h6000_2000, d, r, lat);
    check("pl_aa_strobe", d, 32'h11BB_33DD);
    axi_write(32'h6000_210C, 32'h5A5A_0003, 4'hF, r);
    axi_read(32'h6000_210C, d, r, lat);
    check("mbox3", d, 32'h5A5A_0003);
    axi_read(32'h6000_2100, d, r, lat);
    check("mbox0", d, 32'h0);
    axi_write(32'h6000_0014, 32'h1234_5678, 4'b0011, r);
    axi_read(32'h6000_0014, d, r, lat);
    check("soc_up5_strobe", d, 32'h0000_5678);

    // Caravel reset drops fw_ready but keeps registers
    @(negedge clk); resetb_0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("fw_drop_mprj", {30'd0, mprj}, 32'd0);
    axi_read(32'h6000_7000, d, r, lat);
    check("fw_drop_pl_is", d, 32'd3);
    axi_read(32'h6000_5000, d, r, lat);
    check("fw_drop_gate", {30'd0, r}, 32'd2);
    @(negedge clk); resetb_0 = 1'b1;
    repeat (BC + 3) @(posedge clk);
    #1 check("fw_back_mprj", {30'd0, mprj}, 32'd3);

    // AW+W and AR presented together: write must win
    @(negedge clk);
    awaddr = 32'h6000_2000; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h6000_2000; arvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check("race_awready", {31'd0, awready}, 32'd1);
    check("race_arready_low", {31'd0, arready}, 32'd0);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    check("race_bvalid", {31'd0, bvalid}, 32'd1);
    bready = 1'b1; @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("race_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    @(negedge clk);
    check("race_rvalid", {31'd0, rvalid}, 32'd1);
    check("race_rdata", rdata, 32'hCAFE_F00D);

    // sys_reset while RVALID is pending
    sys_reset = 1'b0;
    #1;
    check("abort_rvalid", {31'd0, rvalid}, 32'd0);
    check("abort_mprj", {30'd0, mprj}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); sys_reset = 1'b1;
    axi_read(32'h6000_7000, d, r, lat);
    check("post_rst_pl_is", d, 32'd0);
    axi_read(32'h6000_2000, d, r, lat);
    check("post_rst_pl_aa", d, 32'd0);
    axi_read(32'h6000_210C, d, r, lat);
    check("post_rst_mbox3", d, 32'd0);
    repeat (BC + 3) @(posedge clk);
    axi_write(32'h6000_7000, 32'h3, 4'hF, r);
    axi_read(32'h6000_5000, d, r, lat);
    check("post_rst_cc", d, 32'h1F); check("post_rst_cc_resp", {30'd0, r}, 32'd0);
    axi_read(32'h6000_0014, d, r, lat);
    check("post_rst_up5", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
